// File: rtl/pipe_ctrl.sv
// Pipeline control for the 5-stage core: turns hazard, redirect, memory-busy and
// halt requests into per-stage enables, flushes and bubbles, plus perf counters.
module pipe_ctrl #(
    parameter int MAX_STALL = 4,
    parameter int DRAIN     = 3,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          insert_nop,
    input  logic [2:0]    PCSrc,
    input  logic          imem_stall,
    input  logic          dmem_stall,
    input  logic          halt,
    output logic          pc_en,
    output logic          fd_en,
    output logic          fd_flush,
    output logic          de_en,
    output logic          de_bubble,
    output logic          em_en,
    output logic          mw_en,
    output logic          halted,
    output logic          stall_err,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);
    localparam int RW = $clog2(MAX_STALL + 2);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL + 1);

    typedef enum logic [1:0] {RUN, MEMW, HALT_DRAIN, HALTED} state_t;

    state_t        state_reg, state_next;
    logic          pending_reg, pending_next;
    logic [DW-1:0] drain_reg, drain_next;
    logic [RW-1:0] run_reg;
    logic          err_reg;
    logic          redirect, nop_applied, flush_take;

    assign redirect  = (PCSrc != 3'b000) || pending_reg;
    assign halted    = (state_reg == HALTED);
    assign stall_err = err_reg;

    always_comb begin
        state_next   = state_reg;
        pending_next = pending_reg;
        drain_next   = drain_reg;
        nop_applied  = 1'b0;
        flush_take   = 1'b0;
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        fd_flush     = 1'b0;
        de_en        = 1'b1;
        de_bubble    = 1'b0;
        em_en        = 1'b1;
        mw_en        = 1'b1;
        // While reset is held the outputs show their reset values regardless of inputs.
        if (rst) begin
            case (state_reg)
                HALTED: begin
                    {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
                end
                HALT_DRAIN: begin
                    if (dmem_stall) begin
                        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
                    end else begin
                        pc_en     = 1'b0;
                        fd_en     = 1'b0;
                        de_bubble = 1'b1;
                        if (drain_reg == DW'(DRAIN - 1))
                            state_next = HALTED;
                        else
                            drain_next = drain_reg + 1'b1;
                    end
                end
                default: begin
                    if (dmem_stall) begin
                        {pc_en, fd_en, de_en, em_en, mw_en} = 5'b00000;
                        state_next = MEMW;
                        if (PCSrc != 3'b000)
                            pending_next = 1'b1;
                    end else begin
                        state_next = RUN;
                        if (redirect) begin
                            // Decode holds a wrong-path instruction, so any stall request is moot.
                            fd_flush     = 1'b1;
                            de_bubble    = 1'b1;
                            pending_next = 1'b0;
                            flush_take   = 1'b1;
                        end else if (insert_nop) begin
                            pc_en       = 1'b0;
                            fd_en       = 1'b0;
                            de_bubble   = 1'b1;
                            nop_applied = 1'b1;
                        end else if (imem_stall) begin
                            pc_en    = 1'b0;
                            fd_flush = 1'b1;
                        end else if (halt) begin
                            state_next = HALT_DRAIN;
                            drain_next = '0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= RUN;
            pending_reg <= 1'b0;
            drain_reg   <= '0;
            run_reg     <= '0;
            err_reg     <= 1'b0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else begin
            state_reg   <= state_next;
            pending_reg <= pending_next;
            drain_reg   <= drain_next;
            if (nop_applied) begin
                if (run_reg != RUN_MAX)
                    run_reg <= run_reg + 1'b1;
                // This stall makes the run longer than MAX_STALL.
                if (run_reg >= RW'(MAX_STALL))
                    err_reg <= 1'b1;
            end else begin
                run_reg <= '0;
            end
            if (!pc_en && state_reg != HALTED && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_take && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: stimulus tables push expected outputs into a scoreboard
// queue; a negedge checker pops and compares one record per cycle.
module tb_pipe_ctrl;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          insert_nop = 1'b0;
    logic [2:0]    PCSrc = 3'b000;
    logic          imem_stall = 1'b0;
    logic          dmem_stall = 1'b0;
    logic          halt = 1'b0;
    logic          pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en;
    logic          halted, stall_err;
    logic [CW-1:0] stall_cnt, flush_cnt;

    pipe_ctrl #(.MAX_STALL(4), .DRAIN(3), .CW(CW)) dut (
        .clk(clk), .rst(rst), .insert_nop(insert_nop), .PCSrc(PCSrc),
        .imem_stall(imem_stall), .dmem_stall(dmem_stall), .halt(halt),
        .pc_en(pc_en), .fd_en(fd_en), .fd_flush(fd_flush), .de_en(de_en),
        .de_bubble(de_bubble), .em_en(em_en), .mw_en(mw_en), .halted(halted),
        .stall_err(stall_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    // ctrl = {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en}
    localparam logic [6:0] N  = 7'b1101011;
    localparam logic [6:0] NP = 7'b0001111;
    localparam logic [6:0] RD = 7'b1111111;
    localparam logic [6:0] IM = 7'b0111011;
    localparam logic [6:0] FZ = 7'b0000000;

    typedef struct {
        logic       nop;
        logic [2:0] pc;
        logic       imem;
        logic       dmem;
        logic       hlt;
        logic [6:0] ctrl;
        logic       hl;
        logic       err;
        int         scnt;
        int         fcnt;
    } vec_t;

    vec_t  tab[$];
    vec_t  sb[$];
    int    total = 0;
    int    bad = 0;
    int    vec_idx = 0;
    string phase = "none";

    function automatic vec_t mk(logic nop, logic [2:0] pc, logic imem, logic dmem, logic hlt,
                                logic [6:0] ctrl, logic hl, logic err, int scnt, int fcnt);
        vec_t v;
        v.nop = nop; v.pc = pc; v.imem = imem; v.dmem = dmem; v.hlt = hlt;
        v.ctrl = ctrl; v.hl = hl; v.err = err; v.scnt = scnt; v.fcnt = fcnt;
        return v;
    endfunction

    task automatic check(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s %s[%0d] got=%0h expected=%0h", phase, nm, idx, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t v;
            v = sb.pop_front();
            check("ctrl", vec_idx, 32'({pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en}), 32'(v.ctrl));
            check("halted", vec_idx, 32'(halted), 32'(v.hl));
            check("stall_err", vec_idx, 32'(stall_err), 32'(v.err));
            check("stall_cnt", vec_idx, 32'(stall_cnt), 32'(v.scnt));
            check("flush_cnt", vec_idx, 32'(flush_cnt), 32'(v.fcnt));
            $display("%s[%0d] nop=%0b pc=%0d imem=%0b dmem=%0b halt=%0b ctrl=%07b halted=%0b err=%0b scnt=%0d fcnt=%0d",
                     phase, vec_idx, v.nop, v.pc, v.imem, v.dmem, v.hlt,
                     {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en},
                     halted, stall_err, stall_cnt, flush_cnt);
            vec_idx++;
        end
    end

    task automatic drive_idle();
        insert_nop = 1'b0; PCSrc = 3'b000; imem_stall = 1'b0; dmem_stall = 1'b0; halt = 1'b0;
    endtask

    task automatic run_tab(input string nm);
        phase = nm;
        vec_idx = 0;
        for (int i = 0; i < tab.size(); i++) begin
            @(posedge clk);
            #1;
            insert_nop = tab[i].nop; PCSrc = tab[i].pc; imem_stall = tab[i].imem;
            dmem_stall = tab[i].dmem; halt = tab[i].hlt;
            sb.push_back(tab[i]);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        drive_idle();
        if (sb.size() != 0) check("sb_drain", 0, 32'(sb.size()), 32'd0);
        tab.delete();
    endtask

    // Assert reset with busy inputs; outputs and counters must show reset values.
    task automatic do_reset(input string nm);
        phase = nm;
        @(posedge clk);
        #1;
        rst = 1'b0;
        insert_nop = 1'b1; dmem_stall = 1'b1; PCSrc = 3'd4; halt = 1'b1;
        #2;
        check("rst_ctrl", 0, 32'({pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en}), 32'(N));
        check("rst_flags", 0, 32'({halted, stall_err}), 32'd0);
        check("rst_cnts", 0, 32'({stall_cnt, flush_cnt}), 32'd0);
        $display("%s reset ctrl=%07b halted=%0b err=%0b scnt=%0d fcnt=%0d", nm,
                 {pc_en, fd_en, fd_flush, de_en, de_bubble, em_en, mw_en},
                 halted, stall_err, stall_cnt, flush_cnt);
        @(negedge clk);
        drive_idle();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // Main function and priority ordering within one reset session.
        do_reset("basic");
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 0, 0));
        tab.push_back(mk(1, 3'd0, 0, 0, 0, NP, 0, 0, 0, 0));
        tab.push_back(mk(1, 3'd0, 0, 0, 0, NP, 0, 0, 1, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 2, 0));
        tab.push_back(mk(1, 3'd3, 0, 0, 0, RD, 0, 0, 2, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 2, 1));
        tab.push_back(mk(0, 3'd0, 1, 0, 0, IM, 0, 0, 2, 1));
        tab.push_back(mk(0, 3'd2, 0, 1, 0, FZ, 0, 0, 3, 1));
        tab.push_back(mk(0, 3'd0, 0, 1, 0, FZ, 0, 0, 4, 1));
        tab.push_back(mk(0, 3'd0, 0, 1, 0, FZ, 0, 0, 5, 1));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, RD, 0, 0, 6, 1));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 6, 2));
        tab.push_back(mk(1, 3'd0, 0, 1, 0, FZ, 0, 0, 6, 2));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 7, 2));
        tab.push_back(mk(1, 3'd0, 1, 0, 0, NP, 0, 0, 7, 2));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 8, 2));
        tab.push_back(mk(0, 3'd0, 1, 0, 1, IM, 0, 0, 8, 2));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 9, 2));
        tab.push_back(mk(0, 3'd1, 1, 0, 0, RD, 0, 0, 9, 2));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N,  0, 0, 9, 3));
        run_tab("basic");

        // Watchdog: six stall cycles, error visible from the sixth cycle and sticky.
        do_reset("watchdog");
        for (int k = 0; k < 6; k++)
            tab.push_back(mk(1, 3'd0, 0, 0, 0, NP, 0, (k == 5), k, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N, 0, 1, 6, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N, 0, 1, 6, 0));
        run_tab("watchdog");

        // Halt drain, then frozen regardless of requests.
        do_reset("halt");
        tab.push_back(mk(0, 3'd0, 0, 0, 1, N,  0, 0, 0, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, NP, 0, 0, 0, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, NP, 0, 0, 1, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, NP, 0, 0, 2, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, FZ, 1, 0, 3, 0));
        tab.push_back(mk(1, 3'd1, 1, 1, 0, FZ, 1, 0, 3, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, FZ, 1, 0, 3, 0));
        run_tab("halt");

        // Memory stall in the middle of the drain pauses it for one cycle.
        do_reset("drain_pause");
        tab.push_back(mk(0, 3'd0, 0, 0, 1, N,  0, 0, 0, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, NP, 0, 0, 0, 0));
        tab.push_back(mk(0, 3'd0, 0, 1, 0, FZ, 0, 0, 1, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, NP, 0, 0, 2, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, NP, 0, 0, 3, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, FZ, 1, 0, 4, 0));
        tab.push_back(mk(1, 3'd5, 0, 0, 0, FZ, 1, 0, 4, 0));
        run_tab("drain_pause");

        // A redirect pending behind a memory stall must not survive reset.
        do_reset("pre_reset");
        tab.push_back(mk(0, 3'd2, 0, 1, 0, FZ, 0, 0, 0, 0));
        run_tab("pre_reset");
        do_reset("reset_mid");
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N, 0, 0, 0, 0));
        tab.push_back(mk(0, 3'd0, 0, 0, 0, N, 0, 0, 0, 0));
        run_tab("reset_mid");

        // Counter saturation at all-ones for the 8-bit counters.
        do_reset("saturate");
        phase = "saturate";
        @(posedge clk);
        #1;
        imem_stall = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        imem_stall = 1'b0;
        PCSrc = 3'd1;
        repeat (300) @(posedge clk);
        #1;
        drive_idle();
        @(negedge clk);
        check("stall_sat", 0, 32'(stall_cnt), 32'd255);
        check("flush_sat", 0, 32'(flush_cnt), 32'd255);
        check("sat_err", 0, 32'(stall_err), 32'd0);
        $display("saturate scnt=%0d fcnt=%0d err=%0b", stall_cnt, flush_cnt, stall_err);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Pipeline control unit at the consuming end of the hazard detector's stall request. Also consumes the execute-stage redirect (PCSrc) and multi-cycle memory busy signals.
- Turns these requests into per-stage register enables, fetch/decode flushes and decode-to-execute bubble insertion for the 5-stage core (F, D, E, M, W).
- Owns halt draining, stall/flush performance counters and a stuck-stall watchdog.

Parameters:
- MAX_STALL, 4: consecutive insert_nop cycles allowed before the watchdog fires.
- DRAIN, 3: bubble cycles issued after halt before the pipeline freezes.
- CW, 16: width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset (reset asserted while rst==0).
- insert_nop  in  1  stall request from the hazard unit.
- PCSrc  in  3  execute-stage next-PC select; 3'b000 = sequential, any nonzero value = redirect (taken branch/jump).
- imem_stall  in  1  instruction memory busy.
- dmem_stall  in  1  data memory busy.
- halt  in  1  halt instruction decoded in D.
- pc_en  out  1  PC register load enable.
- fd_en  out  1  F/D pipeline register enable.
- fd_flush  out  1  load NOP into F/D.
- de_en  out  1  D/E pipeline register enable.
- de_bubble  out  1  load NOP (all write/mem controls 0) into D/E.
- em_en  out  1  E/M pipeline register enable.
- mw_en  out  1  M/W pipeline register enable.
- halted  out  1  pipeline frozen after halt.
- stall_err  out  1  sticky watchdog flag.
- stall_cnt  out  CW  cycles with pc_en==0 outside HALT.
- flush_cnt  out  CW  redirects accepted.

Behaviour:
- Reset (async, rst==0):
  - State = RUN.
  - All enables = 1; fd_flush = de_bubble = 0.
  - halted = stall_err = 0; counters = 0; pending_redir = 0; stall run counter = 0.
- Outputs are Moore/Mealy mix: control outputs are combinational from state and current inputs (zero latency); counters and flags update at the clock edge.
- States: RUN, MEMW, HALT_DRAIN, HALTED.
- Priority within a cycle: dmem_stall > redirect > insert_nop > imem_stall > halt.
- dmem_stall=1 (any non-HALTED state):
  - All five enables = 0; fd_flush = de_bubble = 0; state goes to MEMW.
  - A redirect seen in this cycle sets pending_redir.
  - Leave MEMW on the first cycle with dmem_stall=0. If pending_redir is set, that cycle performs the redirect action and clears pending_redir.
- Redirect (PCSrc != 0, or pending_redir, with dmem_stall=0):
  - pc_en = fd_en = de_en = em_en = mw_en = 1; fd_flush = 1; de_bubble = 1.
  - flush_cnt += 1.
  - insert_nop is ignored in this cycle because the decode instruction is wrong-path.
- insert_nop=1 (no redirect, no dmem_stall):
  - pc_en = fd_en = 0; de_en = 1 with de_bubble = 1; em_en = mw_en = 1.
- imem_stall=1 alone:
  - pc_en = 0; fd_en = 1 with fd_flush = 1; downstream enables = 1.
- halt=1 with no higher request:
  - Enter HALT_DRAIN. There, pc_en = fd_en = 0 and de_bubble = 1 for DRAIN cycles; E/M/W enabled.
  - Then go to HALTED: all enables 0, halted = 1. HALTED exits only via reset.
  - dmem_stall during drain freezes everything and pauses the drain count.
- Watchdog: a run counter counts consecutive cycles with insert_nop=1 that are actually applied as stalls. It clears on any cycle without such a stall. When the count exceeds MAX_STALL, stall_err is set sticky until reset.
- Counters:
  - stall_cnt increments every cycle with pc_en==0 in states RUN/MEMW/HALT_DRAIN.
  - Both counters saturate at all-ones (no wrap).
- Reset mid-stall or mid-drain: immediate return to reset values; no pending state survives.

Test Plan:
- Reset release, idle inputs -> all enables 1, fd_flush=de_bubble=0, counters 0, halted=0.
- insert_nop=1 for 2 cycles -> pc_en=fd_en=0 and de_bubble=1 both cycles; stall_cnt=2; stall_err=0.
- PCSrc=3'b011 and insert_nop=1 in the same cycle -> fd_flush=1, de_bubble=1, pc_en=1; flush_cnt=1; stall_cnt unchanged.
- dmem_stall=1 for 3 cycles with PCSrc=3'b010 in the first of them -> all enables 0 for 3 cycles. Next cycle (dmem_stall=0, PCSrc=0) performs the flush; flush_cnt=1.
- insert_nop held 6 cycles, MAX_STALL=4 -> stall_err rises after the 5th stall cycle and stays 1 after insert_nop drops.
- halt=1 one cycle, DRAIN=3 -> 3 bubble cycles, then halted=1 with all enables 0. It stays there until rst=0 restores reset values.
